// File: rtl/dsi_tx_cmd_arbiter_pkg.sv
// Shared types and constants for the two-source DSI TX command arbiter.
package dsi_arb_pkg;

  localparam int NUM_REQ = 2;

  localparam int VC_W = 2;
  localparam int DT_W = 6;
  localparam int BC_W = 16;
  localparam int PL_W = 32;

  localparam logic [DT_W-1:0] DT_DCS_SW0 = 6'h05;
  localparam logic [DT_W-1:0] DT_DCS_SW1 = 6'h15;
  localparam logic [DT_W-1:0] DT_DCS_LW  = 6'h39;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Index of the set bit of a one-hot grant; with two requesters it is bit 1.
  function automatic logic onehot_idx(input logic [NUM_REQ-1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/dsi_tx_cmd_arbiter_if.sv
// Host-side DSI TX command/payload bus shared by the arbiter and the host controller.
interface dsi_tx_cmd_arbiter_if;
  import dsi_arb_pkg::*;

  logic            cmd_req;
  logic [VC_W-1:0] cmd_vc;
  logic [DT_W-1:0] cmd_data_type;
  logic [BC_W-1:0] cmd_byte_count;
  logic            hs_mode;
  logic [PL_W-1:0] payload;
  logic            cmd_ack;
  logic            active;
  logic            payload_en;
  logic            payload_en_last;
  logic            lp_rx_timeout;

  modport master (
    output cmd_req, cmd_vc, cmd_data_type, cmd_byte_count, hs_mode, payload,
    input  cmd_ack, active, payload_en, payload_en_last, lp_rx_timeout
  );

  modport slave (
    input  cmd_req, cmd_vc, cmd_data_type, cmd_byte_count, hs_mode, payload,
    output cmd_ack, active, payload_en, payload_en_last, lp_rx_timeout
  );

endinterface

// File: rtl/dsi_tx_cmd_arbiter_pick.sv
// Combinational winner selection between the two command sources (one-hot result).
module dsi_arb_pick
  import dsi_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_win,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    win = '0;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11: begin
        // On a tie, round-robin hands the grant to whoever did not win last.
        if (PRIORITY_MODE == 1) win = 2'b01;
        else                    win = last_win ? 2'b01 : 2'b10;
      end
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/dsi_tx_cmd_arbiter.sv
// Arbitrates the single DSI host TX packet interface between the init sequencer and the runtime command source.
module dsi_tx_cmd_arbiter
  import dsi_arb_pkg::*;
#(
  parameter int          PRIORITY_MODE = 0,
  parameter int unsigned ACK_TIMEOUT   = 4095,
  parameter int          TOW           = 16
) (
  input  logic                    TxByteClkHS,
  input  logic                    rstn,
  input  logic                    video_lock,
  input  logic [NUM_REQ-1:0]      r_req,
  input  logic [2*VC_W-1:0]       r_vc,
  input  logic [2*DT_W-1:0]       r_dt,
  input  logic [2*BC_W-1:0]       r_bc,
  input  logic [NUM_REQ-1:0]      r_hs,
  input  logic [2*PL_W-1:0]       r_payload,
  output logic [NUM_REQ-1:0]      r_ack,
  output logic [NUM_REQ-1:0]      r_payload_en,
  output logic [NUM_REQ-1:0]      r_done,
  output logic [NUM_REQ-1:0]      r_err,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    busy,
  dsi_tx_cmd_arbiter_if.master    host
);

  localparam logic [TOW-1:0] TIMEOUT = TOW'(ACK_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               ptr_q, ptr_d;
  logic [TOW-1:0]     cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic [VC_W-1:0]    vc_q, vc_d;
  logic [DT_W-1:0]    dt_q, dt_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic               hs_q, hs_d;
  logic               cmd_req_q, cmd_req_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [NUM_REQ-1:0] win;
  logic               unused_last;

  assign unused_last = host.payload_en_last;

  dsi_arb_pick #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_pick (
    .req      (r_req),
    .last_win (ptr_q),
    .win      (win)
  );

  always_ff @(posedge TxByteClkHS or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
      vc_q      <= '0;
      dt_q      <= '0;
      bc_q      <= '0;
      hs_q      <= 1'b0;
      cmd_req_q <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      vc_q      <= vc_d;
      dt_q      <= dt_d;
      bc_q      <= bc_d;
      hs_q      <= hs_d;
      cmd_req_q <= cmd_req_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    vc_d      = vc_q;
    dt_d      = dt_q;
    bc_d      = bc_q;
    hs_d      = hs_q;
    cmd_req_d = 1'b0;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        seen_d = 1'b0;
        if (!video_lock && (r_req != '0)) begin
          gnt_d   = win;
          vc_d    = win[1] ? r_vc[2*VC_W-1:VC_W] : r_vc[VC_W-1:0];
          dt_d    = win[1] ? r_dt[2*DT_W-1:DT_W] : r_dt[DT_W-1:0];
          bc_d    = win[1] ? r_bc[2*BC_W-1:BC_W] : r_bc[BC_W-1:0];
          hs_d    = win[1] ? r_hs[1] : r_hs[0];
          state_d = REQ;
        end
      end

      REQ: begin
        cnt_d     = cnt_q + TOW'(1);
        cmd_req_d = 1'b1;
        if (host.lp_rx_timeout) begin
          cmd_req_d = 1'b0;
          err_d     = gnt_q;
          state_d   = RELEASE;
        end else if (host.cmd_ack) begin
          cmd_req_d = 1'b0;
          ack_d     = gnt_q;
          cnt_d     = '0;
          state_d   = ACTIVE;
        end else if (cnt_q == TIMEOUT) begin
          cmd_req_d = 1'b0;
          err_d     = gnt_q;
          state_d   = RELEASE;
        end
      end

      ACTIVE: begin
        seen_d = seen_q | host.active;
        if (!seen_q) cnt_d = cnt_q + TOW'(1);
        // An abort wins over a completion seen in the same cycle.
        if (host.lp_rx_timeout) begin
          err_d   = gnt_q;
          state_d = RELEASE;
        end else if (seen_q && !host.active) begin
          done_d  = gnt_q;
          state_d = RELEASE;
        end else if (!seen_q && (cnt_q == TIMEOUT)) begin
          err_d   = gnt_q;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = onehot_idx(gnt_q);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign gnt          = gnt_q;
  assign busy         = (state_q != IDLE);
  assign r_ack        = ack_q;
  assign r_done       = done_q;
  assign r_err        = err_q;
  assign r_payload_en = gnt_q & {NUM_REQ{(state_q == ACTIVE) && host.payload_en}};

  assign host.cmd_req        = cmd_req_q;
  assign host.cmd_vc         = vc_q;
  assign host.cmd_data_type  = dt_q;
  assign host.cmd_byte_count = bc_q;
  assign host.hs_mode        = hs_q;
  assign host.payload        = gnt_q[0] ? r_payload[PL_W-1:0] :
                               gnt_q[1] ? r_payload[2*PL_W-1:PL_W] : '0;

endmodule

// File: tb/tb_dsi_tx_cmd_arbiter.sv
// Directed bench for dsi_tx_cmd_arbiter: round-robin instance dut0 and fixed-priority instance dut1 share all stimulus.
module tb_dsi_tx_cmd_arbiter;
  import dsi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        video_lock = 1'b0;
  logic [1:0]  r_req = '0;
  logic [3:0]  r_vc = '0;
  logic [11:0] r_dt = '0;
  logic [31:0] r_bc = '0;
  logic [1:0]  r_hs = '0;
  logic [63:0] r_payload = '0;
  logic        ack = 1'b0, active = 1'b0, pen = 1'b0, pen_last = 1'b0, lprx = 1'b0;

  logic [1:0] r_ack0, r_pen0, r_done0, r_err0, gnt0;
  logic [1:0] r_ack1, r_pen1, r_done1, r_err1, gnt1;
  logic       busy0, busy1;

  int tests = 0;
  int fails = 0;

  dsi_tx_cmd_arbiter_if hif0 ();
  dsi_tx_cmd_arbiter_if hif1 ();

  assign hif0.cmd_ack = ack;  assign hif0.active = active;  assign hif0.payload_en = pen;
  assign hif0.payload_en_last = pen_last;  assign hif0.lp_rx_timeout = lprx;
  assign hif1.cmd_ack = ack;  assign hif1.active = active;  assign hif1.payload_en = pen;
  assign hif1.payload_en_last = pen_last;  assign hif1.lp_rx_timeout = lprx;

  dsi_tx_cmd_arbiter #(.PRIORITY_MODE(0), .ACK_TIMEOUT(10), .TOW(16)) dut0 (
    .TxByteClkHS(clk), .rstn(rstn), .video_lock(video_lock), .r_req(r_req), .r_vc(r_vc),
    .r_dt(r_dt), .r_bc(r_bc), .r_hs(r_hs), .r_payload(r_payload), .r_ack(r_ack0),
    .r_payload_en(r_pen0), .r_done(r_done0), .r_err(r_err0), .gnt(gnt0), .busy(busy0),
    .host(hif0)
  );

  dsi_tx_cmd_arbiter #(.PRIORITY_MODE(1), .ACK_TIMEOUT(10), .TOW(16)) dut1 (
    .TxByteClkHS(clk), .rstn(rstn), .video_lock(video_lock), .r_req(r_req), .r_vc(r_vc),
    .r_dt(r_dt), .r_bc(r_bc), .r_hs(r_hs), .r_payload(r_payload), .r_ack(r_ack1),
    .r_payload_en(r_pen1), .r_done(r_done1), .r_err(r_err1), .gnt(gnt1), .busy(busy1),
    .host(hif1)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_req(input string name);
    int waited = 0;
    while (!hif0.cmd_req && waited < 6) begin
      cyc();
      waited++;
    end
    tests++;
    if (hif0.cmd_req !== 1'b1) begin
      fails++;
      $display("FAIL %s_cmd_req_wait: cmd_req=%b required 1 within 6 cycles", name, hif0.cmd_req);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({hif0.cmd_req, gnt0, busy0, r_ack0, r_done0, r_err0, r_pen0} !== 10'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0", {hif0.cmd_req, gnt0, busy0, r_ack0, r_done0, r_err0, r_pen0});
    end
    tests++;
    if ({hif0.cmd_data_type, hif0.cmd_byte_count, hif0.cmd_vc, hif0.hs_mode, hif0.payload} !== 57'b0) begin
      fails++;
      $display("FAIL reset_hdr: dt=%h bc=%h payload=%h required 0", hif0.cmd_data_type, hif0.cmd_byte_count, hif0.payload);
    end
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_single_packet();
    int pen_cnt = 0;
    r_req = 2'b01; r_dt[5:0] = DT_DCS_LW; r_bc[15:0] = 16'd8; r_vc[1:0] = 2'd1;
    r_hs[0] = 1'b1; r_payload[31:0] = 32'hA5A5_0001;
    cyc();
    tests++;
    if (gnt0 !== 2'b01 || hif0.cmd_req !== 1'b0) begin
      fails++;
      $display("FAIL single_grant: gnt=%b cmd_req=%b required 01/0", gnt0, hif0.cmd_req);
    end
    cyc();
    tests++;
    if (hif0.cmd_req !== 1'b1 || hif0.cmd_data_type !== 6'h39 || hif0.cmd_byte_count !== 16'd8
        || hif0.cmd_vc !== 2'd1 || hif0.hs_mode !== 1'b1) begin
      fails++;
      $display("FAIL single_hdr: req=%b dt=%h bc=%0d vc=%0d hs=%b required 1/39/8/1/1",
               hif0.cmd_req, hif0.cmd_data_type, hif0.cmd_byte_count, hif0.cmd_vc, hif0.hs_mode);
    end
    cyc(); cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    tests++;
    if (hif0.cmd_req !== 1'b0 || r_ack0 !== 2'b01) begin
      fails++;
      $display("FAIL single_ack: cmd_req=%b r_ack=%b required 0/01", hif0.cmd_req, r_ack0);
    end
    r_req = 2'b00; r_dt[5:0] = DT_DCS_SW0;
    for (int i = 0; i < 6; i++) begin
      active = 1'b1; pen = (i == 2 || i == 3); pen_last = (i == 3);
      #1;
      if (r_pen0 == 2'b01) pen_cnt++;
      if (i == 1) begin
        tests++;
        if (r_ack0 !== 2'b00) begin
          fails++;
          $display("FAIL single_ack_pulse: r_ack=%b required 00", r_ack0);
        end
      end
      if (i == 2) begin
        tests++;
        if (hif0.payload !== 32'hA5A5_0001 || r_pen0 !== 2'b01) begin
          fails++;
          $display("FAIL single_payload: payload=%h r_payload_en=%b required a5a50001/01", hif0.payload, r_pen0);
        end
      end
      cyc();
    end
    active = 1'b0; pen = 1'b0; pen_last = 1'b0;
    tests++;
    if (pen_cnt != 2 || hif0.cmd_data_type !== 6'h39 || r_done0 !== 2'b00) begin
      fails++;
      $display("FAIL single_active: pen_cnt=%0d dt=%h r_done=%b required 2/39/00", pen_cnt, hif0.cmd_data_type, r_done0);
    end
    cyc();
    tests++;
    if (r_done0 !== 2'b01 || gnt0 !== 2'b01) begin
      fails++;
      $display("FAIL single_done: r_done=%b gnt=%b required 01/01", r_done0, gnt0);
    end
    cyc();
    tests++;
    if (gnt0 !== 2'b00 || busy0 !== 1'b0 || r_done0 !== 2'b00) begin
      fails++;
      $display("FAIL single_release: gnt=%b busy=%b r_done=%b required 00/0/00", gnt0, busy0, r_done0);
    end
  endtask

  task automatic test_ack_timeout();
    int hi = 0;
    r_req = 2'b01;
    cyc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (hif0.cmd_req) hi++;
    end
    tests++;
    if (hi != 10) begin
      fails++;
      $display("FAIL timeout_req_len: cmd_req high %0d cycles required 10", hi);
    end
    cyc();
    tests++;
    if (hif0.cmd_req !== 1'b0 || r_err0 !== 2'b01 || r_done0 !== 2'b00 || r_ack0 !== 2'b00) begin
      fails++;
      $display("FAIL timeout_err: req=%b err=%b done=%b ack=%b required 0/01/00/00", hif0.cmd_req, r_err0, r_done0, r_ack0);
    end
    r_req = 2'b00;
    cyc(); cyc();
    tests++;
    if (busy0 !== 1'b0 || gnt0 !== 2'b00 || r_err0 !== 2'b00) begin
      fails++;
      $display("FAIL timeout_idle: busy=%b gnt=%b err=%b required 0/00/00", busy0, gnt0, r_err0);
    end
  endtask

  task automatic test_short_packet();
    r_req = 2'b10; r_vc[3:2] = 2'd2; r_dt[11:6] = DT_DCS_SW0; r_bc[31:16] = 16'd0;
    r_hs[1] = 1'b0; r_payload[63:32] = 32'h1111_2222;
    cyc(); cyc();
    tests++;
    if (hif0.cmd_req !== 1'b1 || hif0.cmd_vc !== 2'd2 || hif0.cmd_data_type !== 6'h05
        || hif0.cmd_byte_count !== 16'd0 || hif0.hs_mode !== 1'b0 || hif0.payload !== 32'h1111_2222) begin
      fails++;
      $display("FAIL short_hdr: req=%b vc=%0d dt=%h bc=%0d hs=%b pl=%h required 1/2/05/0/0/11112222",
               hif0.cmd_req, hif0.cmd_vc, hif0.cmd_data_type, hif0.cmd_byte_count, hif0.hs_mode, hif0.payload);
    end
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    tests++;
    if (r_ack0 !== 2'b10) begin
      fails++;
      $display("FAIL short_ack: r_ack=%b required 10", r_ack0);
    end
    r_req = 2'b00; active = 1'b1;
    cyc();
    active = 1'b0;
    #1;
    tests++;
    if (r_pen0 !== 2'b00) begin
      fails++;
      $display("FAIL short_pen: r_payload_en=%b required 00", r_pen0);
    end
    cyc();
    tests++;
    if (r_done0 !== 2'b10) begin
      fails++;
      $display("FAIL short_done: r_done=%b required 10", r_done0);
    end
    cyc();
    tests++;
    if (hif0.payload !== 32'h0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL short_idle: payload=%h busy=%b required 0/0", hif0.payload, busy0);
    end
  endtask

  task automatic test_video_lock();
    int n = 0;
    video_lock = 1'b1; r_req = 2'b10;
    repeat (4) cyc();
    tests++;
    if (gnt0 !== 2'b00 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL lock_block: gnt=%b busy=%b required 00/0", gnt0, busy0);
    end
    video_lock = 1'b0;
    while (gnt0 == 2'b00 && n < 2) begin
      cyc();
      n++;
    end
    tests++;
    if (gnt0 !== 2'b10) begin
      fails++;
      $display("FAIL lock_release_grant: gnt=%b required 10 within 2 cycles", gnt0);
    end
    wait_cmd_req("lock");
    ack = 1'b1;
    cyc();
    ack = 1'b0; r_req = 2'b00; active = 1'b1;
    cyc();
    video_lock = 1'b1;
    cyc(); cyc();
    active = 1'b0;
    cyc();
    tests++;
    if (r_done0 !== 2'b10 || r_err0 !== 2'b00) begin
      fails++;
      $display("FAIL lock_mid_packet: r_done=%b r_err=%b required 10/00", r_done0, r_err0);
    end
    cyc();
    video_lock = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] exp0 [4];
    exp0[0] = 2'b01; exp0[1] = 2'b10; exp0[2] = 2'b01; exp0[3] = 2'b10;
    r_req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_cmd_req("contend");
      tests++;
      if (gnt0 !== exp0[p]) begin
        fails++;
        $display("FAIL contend_rr_%0d: gnt=%b required %b", p, gnt0, exp0[p]);
      end
      tests++;
      if (gnt1 !== 2'b01) begin
        fails++;
        $display("FAIL contend_fixed_%0d: gnt=%b required 01", p, gnt1);
      end
      ack = 1'b1;
      cyc();
      ack = 1'b0; active = 1'b1;
      if (p == 3) r_req = 2'b00;
      cyc();
      active = 1'b0;
      cyc(); cyc();
    end
    cyc();
    tests++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL contend_idle: busy0=%b busy1=%b required 0/0", busy0, busy1);
    end
  endtask

  task automatic test_lp_rx_timeout();
    r_req = 2'b01;
    wait_cmd_req("lprx");
    ack = 1'b1;
    cyc();
    ack = 1'b0; r_req = 2'b00; active = 1'b1;
    cyc();
    lprx = 1'b1; active = 1'b0;
    cyc();
    lprx = 1'b0;
    tests++;
    if (r_err0 !== 2'b01 || r_done0 !== 2'b00) begin
      fails++;
      $display("FAIL lprx_err: r_err=%b r_done=%b required 01/00", r_err0, r_done0);
    end
    cyc();
    tests++;
    if (r_done0 !== 2'b00 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL lprx_idle: r_done=%b busy=%b required 00/0", r_done0, busy0);
    end
  endtask

  task automatic test_reset_mid_req();
    r_req = 2'b10;
    cyc(); cyc();
    tests++;
    if (hif0.cmd_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_req: cmd_req=%b required 1", hif0.cmd_req);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if ({hif0.cmd_req, gnt0, busy0, r_ack0, r_done0, r_err0, r_pen0} !== 10'b0
        || hif0.cmd_data_type !== 6'h0 || hif0.payload !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_req: ctrl=%b dt=%h payload=%h required 0",
               {hif0.cmd_req, gnt0, busy0, r_ack0, r_done0, r_err0, r_pen0}, hif0.cmd_data_type, hif0.payload);
    end
    r_req = 2'b00;
    cyc();
    rstn = 1'b1;
    cyc();
    tests++;
    if (busy0 !== 1'b0 || hif0.cmd_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_after: busy=%b cmd_req=%b required 0/0", busy0, hif0.cmd_req);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_ack_timeout();
    test_short_packet();
    test_video_lock();
    test_contention();
    test_lp_rx_timeout();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsi_tx_cmd_arbiter.md
Name: dsi_tx_cmd_arbiter

Overview:
Shares the single MIPI DSI host TX packet interface (cmd_req/ack, payload_en, tx_active) between two command sources.
- Requester 0: panel-init packet sequencer (FIFO-driven DCS packets).
- Requester 1: runtime/bypass command source (brightness, sleep in/out).
- Latches the winner's packet header, runs the host handshake, routes payload strobes back to the winner, and enforces ack/activity timeouts.
- Blocks new grants while video streaming is locked.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 wins.
ACK_TIMEOUT, 16'd4095, TxByteClkHS cycles allowed from cmd_req assertion to cmd_ack, and from cmd_ack to first tx_active high.
TOW, 16, width of the timeout counter.

Ports:
TxByteClkHS  in  1  byte clock; all logic on its rising edge
rstn  in  1  asynchronous active-low reset
video_lock  in  1  high = no new grants (DPI stream running)
r_req  in  2  per-requester packet request, level, held until r_ack or r_err
r_vc  in  4  {vc1,vc0}, 2 bits each
r_dt  in  12  {dt1,dt0}, 6 bits each
r_bc  in  32  {bc1,bc0}, 16 bits each, payload byte count (0 = short packet)
r_hs  in  2  per-requester HS-mode request
r_payload  in  64  {p1,p0}, 32 bits each
r_ack  out  2  one-cycle pulse: host accepted the granted command
r_payload_en  out  2  host_tx_payload_en routed to the granted requester
r_done  out  2  one-cycle pulse: packet completed
r_err  out  2  one-cycle pulse: timeout or lp_rx_timeout abort
gnt  out  2  one-hot current grant
busy  out  1  state != IDLE
host_tx_cmd_req  out  1  command request to host
host_tx_cmd_vc  out  2  latched VC
host_tx_cmd_data_type  out  6  latched data type
host_tx_cmd_byte_count  out  16  latched byte count
host_tx_hs_mode  out  1  latched HS mode
host_tx_payload  out  32  granted requester's payload, combinational mux
host_tx_cmd_ack  in  1  host accepts command
host_tx_active  in  1  host transmitting
host_tx_payload_en  in  1  host consumes a payload word this cycle
host_tx_payload_en_last  in  1  last payload word
lp_rx_timeout  in  1  PHY LP receive timeout

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer points at requester 0, timeout counter 0. Reset asserted mid-packet drops host_tx_cmd_req immediately with no r_done/r_err pulse.
- IDLE:
  - If video_lock = 0 and r_req != 0, pick a winner. Mode 0: the requester other than the last winner wins on a tie. Mode 1: requester 0 wins.
  - Register gnt and latch vc/dt/bc/hs into the header regs. Go to REQ.
  - Latency from r_req to host_tx_cmd_req is 2 cycles.
- REQ:
  - Assert host_tx_cmd_req. Counter increments each cycle.
  - On host_tx_cmd_ack: drop cmd_req next cycle, pulse r_ack[g], clear counter, go to ACTIVE.
  - If the counter reaches ACK_TIMEOUT: drop cmd_req, pulse r_err[g], go to RELEASE.
- ACTIVE:
  - r_payload_en[g] = host_tx_payload_en; the non-granted bit stays 0.
  - Track seen_active once host_tx_active = 1. Completion is host_tx_active = 0 with seen_active = 1; then pulse r_done[g] and go to RELEASE.
  - If seen_active = 0 and the counter reaches ACK_TIMEOUT: r_err[g], go to RELEASE.
  - lp_rx_timeout in REQ or ACTIVE: r_err[g], go to RELEASE. err takes precedence over done in the same cycle.
- RELEASE: one cycle. Clear gnt, update the round-robin pointer to the last winner, go to IDLE. This guarantees at least 1 idle cycle between packets.
- Grant/header stability: the header is frozen from grant to RELEASE. Changes to r_req or header inputs after grant are ignored. A requester dropping r_req before r_ack does not abort the packet.
- video_lock: asserting it mid-packet does not abort the packet; it only blocks the next grant.
- host_tx_payload is 0 when gnt = 0.
- Both requesters asserting in the same cycle as RELEASE are evaluated in the following IDLE.

Decomposition:
- Package dsi_arb_pkg:
  - state enum {IDLE, REQ, ACTIVE, RELEASE}
  - NUM_REQ = 2
  - DSI data-type constants DT_DCS_SW0 = 6'h05, DT_DCS_SW1 = 6'h15, DT_DCS_LW = 6'h39
  - slice-width constants
- Sub-module dsi_arb_pick: combinational winner selection from r_req, pointer and PRIORITY_MODE, producing a one-hot result.

Test Plan:
- Single packet: r_req = 01, dt0 = 6'h39, bc0 = 16'd8, ack after 3 cycles, active high 6 cycles with 2 payload_en → host_tx_cmd_req high 2 cycles after r_req. r_ack[0] pulses once, r_payload_en[0] pulses twice, r_done[0] one cycle after active falls, gnt = 00 after RELEASE.
- Contention, mode 0: r_req = 11 held for 4 packets → grant order 0, 1, 0, 1. Mode 1 with the same stimulus → grant order 0, 0, 0, 0.
- Ack timeout: ACK_TIMEOUT = 10, never ack → cmd_req drops after 10 cycles, r_err[g] pulses, no r_done, busy = 0 two cycles later.
- Short packet: bc = 0, active pulses 1 cycle, no payload_en → r_done pulses, r_payload_en stays 0.
- video_lock = 1 with r_req = 10 → no grant. Release video_lock → grant to requester 1 within 2 cycles. video_lock rising during ACTIVE → packet still completes with r_done.
- lp_rx_timeout during ACTIVE → r_err[g] pulse, no r_done. Then assert rstn = 0 mid-REQ → host_tx_cmd_req = 0 immediately and all outputs 0.
